// File: rtl/pwm_apb_sequencer_if.sv
// APB bus between the PWM sequencer (master) and the PWM slave.
// Signals: PADDR, PSEL, PENABLE, PWRITE, PWDATA driven by master;
//          PREADY, PSERR, PRDATA driven by slave.
interface pwm_apb_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic                  PSERR;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PSERR, PRDATA
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PSERR, PRDATA
  );
endinterface

// File: rtl/pwm_apb_sequencer.sv
// APB master that programs the PWM slave from a command interface.
// Start: disable, duty, period, length, enable writes. Stop: one disable write.
// Handles wait states, PSERR and a wait-state timeout; reports done/err.
// Ports: PCLK, PRESETn (async active-low); cmd_valid/cmd_ready/cmd_stop/
//        cmd_duty/cmd_period/cmd_length command side; apb (master modport);
//        busy, done, err, err_stage, err_timeout status (all registered).
// Option: define PWM_SEQ_READBACK_EN to read back duty/period/length
//         before the final enable write and abort on a mismatch.
module pwm_apb_sequencer #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_stop,
  input  logic [DATA_WIDTH-1:0] cmd_duty,
  input  logic [DATA_WIDTH-1:0] cmd_period,
  input  logic [DATA_WIDTH-1:0] cmd_length,
  pwm_apb_sequencer_if.master   apb,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            err_stage,
  output logic                  err_timeout
);

`ifdef PWM_SEQ_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  localparam int unsigned WAIT_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t                r_state;
  logic [2:0]            r_idx;
  logic                  r_stop;
  logic [DATA_WIDTH-1:0] r_duty, r_period, r_length;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_cmd_ready, r_busy, r_done, r_err, r_err_timeout;
  logic [2:0]            r_err_stage;
  logic                  r_psel, r_penable, r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;

  logic [2:0]            w_next_idx;
  logic                  w_last, w_rd_bad, w_abort_err, w_abort_to, w_nx_write;
  logic [DATA_WIDTH-1:0] w_expect, w_nx_wdata;
  logic [ADDR_WIDTH-1:0] w_nx_addr, w_addr_idx0;

  // Register offset of each transfer index (idx0/idx4 both hit enable).
  function automatic logic [3:0] f_offset(input logic [2:0] idx);
    case (idx)
      3'd1, 3'd5: f_offset = 4'h0;
      3'd2, 3'd6: f_offset = 4'h4;
      3'd3, 3'd7: f_offset = 4'hC;
      default:    f_offset = 4'h8;
    endcase
  endfunction

  // Transfer sequencing, readback compare and abort detection.
  always_comb begin
    w_next_idx = 3'(r_idx + 3'd1);
    if (r_idx == 3'd3) w_next_idx = READBACK ? 3'd5 : 3'd4;
    if (r_idx == 3'd7) w_next_idx = 3'd4;
    w_last = r_stop || (r_idx == 3'd4);

    w_expect = '0;
    case (r_idx)
      3'd5:    w_expect = r_duty;
      3'd6:    w_expect = r_period;
      3'd7:    w_expect = r_length;
      default: w_expect = '0;
    endcase
    w_rd_bad    = READBACK && (r_idx >= 3'd5) && (apb.PRDATA != w_expect);
    w_abort_err = apb.PREADY && (apb.PSERR || w_rd_bad);
    w_abort_to  = !apb.PREADY && (TIMEOUT_CYCLES != 0) &&
                  (WAIT_W'(r_wait + WAIT_W'(1)) == WAIT_W'(TIMEOUT_CYCLES));

    w_addr_idx0 = ADDR_WIDTH'(BASE_ADDR + ADDR_WIDTH'(4'h8));
    w_nx_addr   = ADDR_WIDTH'(BASE_ADDR + ADDR_WIDTH'(f_offset(w_next_idx)));
    w_nx_write  = !(READBACK && (w_next_idx >= 3'd5));
    case (w_next_idx)
      3'd1:    w_nx_wdata = r_duty;
      3'd2:    w_nx_wdata = r_period;
      3'd3:    w_nx_wdata = r_length;
      3'd4:    w_nx_wdata = DATA_WIDTH'(1);
      default: w_nx_wdata = '0;
    endcase
  end

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_stop        <= 1'b0;
      r_duty        <= '0;
      r_period      <= '0;
      r_length      <= '0;
      r_wait        <= '0;
      r_cmd_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_err_stage   <= '0;
      r_err_timeout <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_stop        <= cmd_stop;
            r_duty        <= cmd_duty;
            r_period      <= cmd_period;
            r_length      <= cmd_length;
            r_idx         <= '0;
            r_wait        <= '0;
            r_err_stage   <= '0;
            r_err_timeout <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_busy        <= 1'b1;
            r_psel        <= 1'b1;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b1;
            r_paddr       <= w_addr_idx0;
            r_pwdata      <= '0;
            r_state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_abort_err || w_abort_to || (apb.PREADY && w_last)) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= w_abort_err || w_abort_to;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            if (w_abort_err || w_abort_to) begin
              r_err_stage   <= r_idx;
              r_err_timeout <= w_abort_to;
            end
          end else if (apb.PREADY) begin
            // Back-to-back: PSEL stays high into the next SETUP.
            r_idx     <= w_next_idx;
            r_wait    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= w_nx_write;
            r_paddr   <= w_nx_addr;
            r_pwdata  <= w_nx_wdata;
            r_state   <= S_SETUP;
          end else begin
            r_wait <= WAIT_W'(r_wait + WAIT_W'(1));
          end
        end
        S_DONE: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign err_stage   = r_err_stage;
  assign err_timeout = r_err_timeout;
  assign apb.PSEL    = r_psel;
  assign apb.PENABLE = r_penable;
  assign apb.PWRITE  = r_pwrite;
  assign apb.PADDR   = r_paddr;
  assign apb.PWDATA  = r_pwdata;

endmodule

// File: tb/tb_pwm_apb_sequencer.sv
// Self-checking bench for pwm_apb_sequencer: a transaction-level model
// expands each command plus a slave behaviour table into a per-cycle
// expected trace that a single compare process checks every cycle.
module tb_pwm_apb_sequencer;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 16;
  localparam logic [31:0] BASE = 32'h4000_1000;
`ifdef PWM_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_stop;
  logic [DW-1:0] cmd_duty, cmd_period, cmd_length;
  logic          busy, done, err, err_timeout;
  logic [2:0]    err_stage;

  pwm_apb_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  pwm_apb_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_stop(cmd_stop),
    .cmd_duty(cmd_duty), .cmd_period(cmd_period), .cmd_length(cmd_length),
    .apb(apb.master),
    .busy(busy), .done(done), .err(err), .err_stage(err_stage), .err_timeout(err_timeout)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        busy, done, err, ready;
    logic [2:0]  stage;
    logic        tmo;
  } obs_t;

  typedef struct packed {
    logic        pready, pserr;
    logic [31:0] prdata;
  } stim_t;

  obs_t        exp_q[$];
  stim_t       stim_q[$];
  logic [63:0] wlog[$];
  int          wait_tab[8];
  int          serr_k, bad_k;

  int   checks = 0, errors = 0;
  obs_t cur_exp;
  bit   chk_en = 1'b0;
  int   cyc = 0, done_cyc = -1;

  function automatic obs_t sample();
    obs_t o;
    o.psel = apb.PSEL;  o.penable = apb.PENABLE; o.pwrite = apb.PWRITE;
    o.paddr = apb.PADDR; o.pwdata = apb.PWDATA;
    o.busy = busy; o.done = done; o.err = err; o.ready = cmd_ready;
    o.stage = err_stage; o.tmo = err_timeout;
    return o;
  endfunction

  // Per-cycle compare against the model trace.
  always @(negedge PCLK) begin
    if (chk_en) begin
      obs_t a;
      a = sample();
      checks++;
      if (a !== cur_exp) begin
        errors++;
        $display("FAIL trace cyc%0d: got %p want %p", cyc, a, cur_exp);
      end
      if (a.done === 1'b1) done_cyc = cyc;
    end
  end

  // Log every completed write as {addr, data}.
  always @(negedge PCLK) begin
    if (PRESETn && apb.PSEL && apb.PENABLE && apb.PREADY && apb.PWRITE)
      wlog.push_back({apb.PADDR, apb.PWDATA});
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [3:0] offs(input int idx);
    case (idx)
      1, 5:    return 4'h0;
      2, 6:    return 4'h4;
      3, 7:    return 4'hC;
      default: return 4'h8;
    endcase
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  task automatic clear_plan();
    foreach (wait_tab[i]) wait_tab[i] = 0;
    serr_k = -1;
    bad_k  = -1;
  endtask

  // Expand a command and slave behaviour into expected outputs per cycle.
  task automatic build(input bit stop, input logic [31:0] d, p, l, output int m_done);
    int   seq[$];
    int   idx;
    bit   aborted, tmo;
    int   stage;
    obs_t o;
    stim_t s;
    logic [31:0] val;
    exp_q.delete();
    stim_q.delete();
    seq = '{0};
    if (!stop) begin
      seq.push_back(1); seq.push_back(2); seq.push_back(3);
      if (RB) begin seq.push_back(5); seq.push_back(6); seq.push_back(7); end
      seq.push_back(4);
    end
    aborted = 0; tmo = 0; stage = 0;
    for (int k = 0; k < seq.size(); k++) begin
      idx = seq[k];
      case (idx)
        1, 5: val = d;
        2, 6: val = p;
        3, 7: val = l;
        4:    val = 32'd1;
        default: val = 32'd0;
      endcase
      o = '0;
      o.psel = 1; o.busy = 1;
      o.pwrite = (idx < 5);
      o.paddr = BASE + 32'(offs(idx));
      o.pwdata = (idx < 5) ? val : 32'd0;
      s = '0;
      exp_q.push_back(o); stim_q.push_back(s);
      o.penable = 1;
      if (TO != 0 && wait_tab[k] >= int'(TO)) begin
        for (int w = 0; w < int'(TO); w++) begin exp_q.push_back(o); stim_q.push_back(s); end
        aborted = 1; tmo = 1; stage = idx;
        break;
      end
      for (int w = 0; w < wait_tab[k]; w++) begin exp_q.push_back(o); stim_q.push_back(s); end
      s.pready = 1;
      s.pserr  = (k == serr_k);
      s.prdata = (idx < 5) ? 32'hDEAD_BEEF : ((k == bad_k) ? (val ^ 32'h1) : val);
      exp_q.push_back(o); stim_q.push_back(s);
      if (k == serr_k || k == bad_k) begin aborted = 1; stage = idx; break; end
    end
    o = '0;
    o.done = 1; o.err = aborted; o.stage = 3'(stage); o.tmo = tmo;
    exp_q.push_back(o); stim_q.push_back('0);
    m_done = exp_q.size();
    o.done = 0; o.err = 0; o.ready = 1;
    exp_q.push_back(o); stim_q.push_back('0);
  endtask

  // Issue one command and play the slave table; rst_at>0 pulses reset then.
  task automatic run(input bit stop, input logic [31:0] d, p, l,
                     input bit spam, input int rst_at, output int m_done);
    build(stop, d, p, l, m_done);
    wlog.delete();
    done_cyc = -1;
    cmd_valid = 1; cmd_stop = stop; cmd_duty = d; cmd_period = p; cmd_length = l;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(posedge PCLK); #1;
      cyc = c + 1;
      cmd_valid  = spam && exp_q[c].busy;
      cmd_stop   = 1'b0;
      cmd_duty   = $urandom; cmd_period = $urandom; cmd_length = $urandom;
      apb.PREADY = stim_q[c].pready;
      apb.PSERR  = stim_q[c].pserr;
      apb.PRDATA = stim_q[c].prdata;
      cur_exp    = exp_q[c];
      if (cyc == rst_at) begin
        chk_en = 0;
        chk("rst_pre_access", {62'd0, apb.PSEL, apb.PENABLE}, 64'd3);
        chk("rst_pre_paddr", {32'd0, apb.PADDR}, {32'd0, BASE + 32'h4});
        #2 PRESETn = 0;
        #1;
        chk("rst_bus_zero", {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA}, 64'd0);
        chk("rst_status", {57'd0, busy, done, err, err_stage, err_timeout}, 64'd0);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 0; apb.PREADY = 0; apb.PSERR = 0;
        @(negedge PCLK);
        PRESETn = 1;
        cur_exp = reset_obs();
        @(posedge PCLK); #1;
        chk_en = 1;
        return;
      end
    end
    cmd_valid = 0; apb.PREADY = 0; apb.PSERR = 0; apb.PRDATA = '0;
  endtask

  int m_done;

  initial begin
    PRESETn = 0; cmd_valid = 0; cmd_stop = 0;
    cmd_duty = '0; cmd_period = '0; cmd_length = '0;
    apb.PREADY = 0; apb.PSERR = 0; apb.PRDATA = '0;
    cur_exp = reset_obs();
    #3 chk_en = 1;
    @(negedge PCLK); @(negedge PCLK);
    PRESETn = 1;
    @(posedge PCLK); #1;

    // Zero-wait start.
    clear_plan();
    run(0, 32'd30, 32'd10, 32'd20, 0, 0, m_done);
    chk("model_start_done", 64'(m_done), RB ? 64'd17 : 64'd11);
    chk("start_done_cyc", 64'(done_cyc), RB ? 64'd17 : 64'd11);
    chk("start_nwrites", 64'(wlog.size()), 64'd5);
    if (wlog.size() == 5) begin
      chk("start_w0", wlog[0], {BASE + 32'h8, 32'd0});
      chk("start_w1", wlog[1], {BASE + 32'h0, 32'd30});
      chk("start_w2", wlog[2], {BASE + 32'h4, 32'd10});
      chk("start_w3", wlog[3], {BASE + 32'hC, 32'd20});
      chk("start_w4", wlog[4], {BASE + 32'h8, 32'd1});
    end

    // Three wait states on idx2.
    clear_plan();
    wait_tab[2] = 3;
    run(0, 32'h55, 32'hAA, 32'h1234, 0, 0, m_done);
    chk("wait_done_cyc", 64'(done_cyc), RB ? 64'd20 : 64'd14);

    // PSERR on idx3.
    clear_plan();
    serr_k = 3;
    run(0, 32'd7, 32'd9, 32'd11, 0, 0, m_done);
    chk("serr_done_cyc", 64'(done_cyc), 64'd9);
    chk("serr_stage", {60'd0, err_stage, err_timeout}, {60'd0, 3'd3, 1'b0});
    chk("serr_nwrites", 64'(wlog.size()), 64'd4);

    // Slave never ready: timeout on idx0.
    clear_plan();
    wait_tab[0] = 100;
    run(0, 32'd1, 32'd2, 32'd3, 0, 0, m_done);
    chk("tmo_done_cyc", 64'(done_cyc), 64'd18);
    chk("tmo_stage", {60'd0, err_stage, err_timeout}, {60'd0, 3'd0, 1'b1});
    chk("tmo_nwrites", 64'(wlog.size()), 64'd0);

    // Stop command with cmd_valid held during busy.
    clear_plan();
    run(1, 32'd5, 32'd6, 32'd7, 1, 0, m_done);
    chk("stop_done_cyc", 64'(done_cyc), 64'd3);
    chk("stop_nwrites", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) chk("stop_w0", wlog[0], {BASE + 32'h8, 32'd0});

    // Reset during idx2 ACCESS, then a clean start.
    clear_plan();
    wait_tab[2] = 3;
    run(0, 32'd40, 32'd50, 32'd60, 0, 7, m_done);
    clear_plan();
    run(0, 32'd12, 32'd34, 32'd56, 0, 0, m_done);
    chk("post_rst_done_cyc", 64'(done_cyc), RB ? 64'd17 : 64'd11);
    chk("post_rst_nwrites", 64'(wlog.size()), 64'd5);

`ifdef PWM_SEQ_READBACK_EN
    // Period readback mismatch.
    clear_plan();
    bad_k = 5;
    run(0, 32'd30, 32'd10, 32'd20, 0, 0, m_done);
    chk("rb_done_cyc", 64'(done_cyc), 64'd13);
    chk("rb_stage", {60'd0, err_stage, err_timeout}, {60'd0, 3'd6, 1'b0});
    chk("rb_nwrites", 64'(wlog.size()), 64'd4);
`endif

    @(posedge PCLK); #1;
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_apb_sequencer.md
# pwm_apb_sequencer

APB master that programs and sequences the APB PWM slave from a simple command interface. A start command issues the full register programming sequence (disable, duty, period, length, enable) as compliant APB writes. A stop command issues a single disable write. The block sits between the system control logic and the PWM slave, handles wait states, slave errors and timeouts, and reports completion status.

## Interface
- DATA_WIDTH, 32, width of PWDATA/PRDATA and command fields
- ADDR_WIDTH, 32, width of PADDR
- BASE_ADDR, 0, PWM slave base address; register offsets: duty 0x0, period 0x4, enable 0x8, length 0xC
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY=0 before abort; 0 disables the timeout
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on edge with cmd_valid&&cmd_ready
- cmd_stop  in  1  1 = stop command, 0 = start command
- cmd_duty / cmd_period / cmd_length  in  DATA_WIDTH each  values for a start command, sampled at accept
- PADDR  out  ADDR_WIDTH  APB address
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PWDATA  out  DATA_WIDTH  APB write data
- PREADY  in  1  slave ready
- PSERR  in  1  slave error, valid when PSEL&&PENABLE&&PREADY
- PRDATA  in  DATA_WIDTH  slave read data
- busy  out  1  high from accept until the final transfer completes or aborts
- done  out  1  one-cycle pulse at the end of every accepted command, including aborted ones
- err  out  1  one-cycle pulse coincident with done when the command aborted
- err_stage  out  3  index of the failing transfer; held until the next accept
- err_timeout  out  1  1 if the abort was a timeout; held until the next accept

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- Command fields are registered at accept.
- Start transfer list, in order:
  - idx0: 0x8 ← 0
  - idx1: 0x0 ← duty
  - idx2: 0x4 ← period
  - idx3: 0xC ← length
  - idx4: 0x8 ← 1
- Stop transfer list: idx0 only (0x8 ← 0).
- PADDR = BASE_ADDR + offset, modulo 2^ADDR_WIDTH.
- IDLE → SETUP on accept.
- SETUP drives PSEL=1, PENABLE=0. SETUP → ACCESS unconditionally.
- ACCESS drives PSEL=1, PENABLE=1.
- The transfer completes on the edge where PREADY=1 in ACCESS. Then:
  - PSERR=1 → abort.
  - Else, more transfers remain → SETUP of the next transfer (back-to-back; PSEL stays 1).
  - Else → DONE.
- PADDR, PWRITE and PWDATA are stable from SETUP through completion.
- Timeout: the wait counter increments on each ACCESS cycle with PREADY=0 and clears on entry to SETUP. When it reaches TIMEOUT_CYCLES, abort at that edge.
- Abort: go to DONE, set err_stage = current idx and err_timeout (1 for timeout, 0 for PSERR). Remaining transfers are never issued; in particular enable is never set.
- DONE (one cycle): done=1, err=1 if aborted, PSEL=0, PENABLE=0. DONE → IDLE.
- cmd_valid is ignored while busy; there is no queueing.
- In IDLE and DONE, PSEL, PENABLE, PWRITE, PADDR and PWDATA are all 0.

## Timing
- Reset values: every output is 0 except cmd_ready = 1. Reset is applied immediately on PRESETn low, mid-transfer included. State returns to IDLE.
- A zero-wait transfer takes 2 cycles.
- Start command, no wait states: SETUP begins in the cycle after accept; done is asserted in cycle 11 after the accept edge; cmd_ready returns the cycle after done.
- Stop command: done in cycle 3 after accept.
- Each wait cycle adds exactly 1 cycle of latency.
- busy = state ∈ {SETUP, ACCESS}.

## Configuration
- PWM_SEQ_READBACK_EN defined: a start command inserts APB reads between idx3 and the final enable write:
  - idx5: read 0x0
  - idx6: read 0x4
  - idx7: read 0xC
  - Reads use PWRITE=0 and PWDATA=0. PRDATA is compared at the completion edge.
  - A mismatch aborts with err_stage = read idx and err_timeout = 0. Enable is not written.
  - The enable write then becomes the final transfer (idx4 issued last).
  - Zero-wait start latency becomes 17 cycles.
- PWM_SEQ_READBACK_EN undefined: no reads are issued, PWRITE is 1 during every transfer, and PRDATA is unused.

## Test plan
- Start, duty=30, period=10, length=20, zero-wait slave → writes in order (0x8,0),(0x0,30),(0x4,10),(0xC,20),(0x8,1); done in cycle 11; err=0.
- PREADY low for 3 cycles on idx2 → ACCESS extended by 3 cycles, PADDR/PWDATA stable throughout, done in cycle 14.
- PSERR=1 on idx3 → no further transfers; done+err pulse; err_stage=3; err_timeout=0; 0x8←1 never seen.
- PREADY stuck low, TIMEOUT_CYCLES=16 → abort after 16 ACCESS wait cycles; PSEL drops; err=1; err_timeout=1; err_stage=0.
- Stop command while PWM running → single write (0x8,0); done in cycle 3; cmd_valid asserted while busy is ignored.
- PRESETn low during idx2 ACCESS → all outputs 0 immediately. After release, cmd_ready=1 and a new start completes normally. With PWM_SEQ_READBACK_EN, a PRDATA mismatch on the period read → err_stage=6 and no enable write.
